// File: rtl/cnt5_pkg.sv
// Shared constants, enums and mod-5 helpers for the mod-5 count stream decoder.
package cnt5_pkg;

    localparam logic [2:0] ZERO  = 3'd0;
    localparam logic [2:0] ONE   = 3'd1;
    localparam logic [2:0] TWO   = 3'd2;
    localparam logic [2:0] THREE = 3'd3;
    localparam logic [2:0] FOUR  = 3'd4;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PRIMED = 2'd1,
        LOCK   = 2'd2
    } dec_state_t;

    typedef enum logic [1:0] {
        UP           = 2'd0,
        DOWN         = 2'd1,
        BAD_STEP     = 2'd2,
        ILLEGAL_CODE = 2'd3
    } step_t;

    function automatic logic [2:0] inc5(input logic [2:0] x);
        return (x >= FOUR) ? ZERO : 3'(x + 3'd1);
    endfunction

    function automatic logic [2:0] dec5(input logic [2:0] x);
        return (x == ZERO) ? FOUR : 3'(x - 3'd1);
    endfunction

endpackage

// File: rtl/cnt5_step_cmp.sv
// Combinational classifier: compares a new mod-5 sample against the previous one.
module cnt5_step_cmp
    import cnt5_pkg::*;
(
    input  logic [2:0] prev,
    input  logic [2:0] cnt_in,
    output step_t      step
);

    // Illegal code is checked first so out-of-range values never alias a step.
    always_comb begin
        step = BAD_STEP;
        if (cnt_in > FOUR)
            step = ILLEGAL_CODE;
        else if (cnt_in == inc5(prev))
            step = UP;
        else if (cnt_in == dec5(prev))
            step = DOWN;
    end

endmodule

// File: rtl/cnt5_dir_decoder.sv
// Recovers up/down direction from a mod-5 count stream, flags bad codes/steps.
// Optional saturating error counter and err_cnt port under CNT5_DEC_ERRCNT_EN.
//
// state  | meaning
// EMPTY  | no reference sample held; next legal sample primes prev
// PRIMED | prev valid, no direction decoded yet
// LOCK   | last step was a legal up/down step; dir is valid
module cnt5_dir_decoder
    import cnt5_pkg::*;
#(
    parameter int RUN_W = 8
`ifdef CNT5_DEC_ERRCNT_EN
    , parameter int ERR_W = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       cnt_in,
    output logic             dir,
    output logic             dir_vld,
    output logic             err,
    output logic [RUN_W-1:0] run_len
`ifdef CNT5_DEC_ERRCNT_EN
    , output logic [ERR_W-1:0] err_cnt
`endif
);

    dec_state_t       state, state_nxt;
    logic [2:0]       prev, prev_nxt;
    logic             dir_nxt, err_nxt;
    logic [RUN_W-1:0] run_nxt;
    step_t            step;

    cnt5_step_cmp u_step_cmp (
        .prev   (prev),
        .cnt_in (cnt_in),
        .step   (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (en) begin
            if (state == EMPTY) begin
                if (step != ILLEGAL_CODE)
                    state_nxt = PRIMED;
            end else begin
                case (step)
                    UP, DOWN: state_nxt = LOCK;
                    BAD_STEP: state_nxt = PRIMED;
                    default:  state_nxt = EMPTY;
                endcase
            end
        end
    end

    // Next values for the registered data outputs.
    always_comb begin
        prev_nxt = prev;
        dir_nxt  = dir;
        run_nxt  = run_len;
        err_nxt  = 1'b0;
        if (en) begin
            if (step != ILLEGAL_CODE)
                prev_nxt = cnt_in;
            if (state == EMPTY) begin
                err_nxt = (step == ILLEGAL_CODE);
            end else begin
                case (step)
                    UP, DOWN: begin
                        dir_nxt = (step == UP);
                        if (state == PRIMED || dir != (step == UP))
                            run_nxt = RUN_W'(1);
                        else if (run_len != '1)
                            run_nxt = run_len + RUN_W'(1);
                    end
                    default: begin
                        err_nxt = 1'b1;
                        run_nxt = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= ZERO;
            dir     <= 1'b0;
            err     <= 1'b0;
            run_len <= '0;
        end else begin
            prev    <= prev_nxt;
            dir     <= dir_nxt;
            err     <= err_nxt;
            run_len <= run_nxt;
        end
    end

    assign dir_vld = (state == LOCK);

`ifdef CNT5_DEC_ERRCNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt <= '0;
        else if (err_nxt && err_cnt != '1)
            err_cnt <= err_cnt + ERR_W'(1);
    end
`endif

endmodule

// File: tb/tb_cnt5_dir_decoder.sv
// Directed self-checking bench for cnt5_dir_decoder (default and RUN_W=3 instances).
module tb_cnt5_dir_decoder;
    import cnt5_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [2:0] cnt_in = 3'd0;
    logic       dir, dir_vld, err;
    logic [7:0] run_len;

    logic       en2 = 1'b0;
    logic [2:0] cnt2 = 3'd0;
    logic       dir2, dir_vld2, err2;
    logic [2:0] run_len2;

`ifdef CNT5_DEC_ERRCNT_EN
    logic [7:0] err_cnt, err_cnt2;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cnt5_dir_decoder #(.RUN_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .cnt_in  (cnt_in),
        .dir     (dir),
        .dir_vld (dir_vld),
        .err     (err),
        .run_len (run_len)
`ifdef CNT5_DEC_ERRCNT_EN
        , .err_cnt (err_cnt)
`endif
    );

    cnt5_dir_decoder #(.RUN_W(3)) dut_sat (
        .clk     (clk),
        .reset   (reset),
        .en      (en2),
        .cnt_in  (cnt2),
        .dir     (dir2),
        .dir_vld (dir_vld2),
        .err     (err2),
        .run_len (run_len2)
`ifdef CNT5_DEC_ERRCNT_EN
        , .err_cnt (err_cnt2)
`endif
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        en2   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic e, input logic [2:0] v);
        @(negedge clk);
        en     = e;
        cnt_in = v;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({dir_vld, dir, err, run_len} !== 11'd0 || dut.state !== EMPTY)
            $display("FAIL reset_state: vld=%0b dir=%0b err=%0b run=%0d state=%0d, want all 0",
                     dir_vld, dir, err, run_len, dut.state);
        else passed++;
`ifdef CNT5_DEC_ERRCNT_EN
        total++;
        if (err_cnt !== 8'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        else passed++;
`endif
    endtask

    task automatic test_up_cycle();
        logic [2:0] seq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        logic [7:0] exp_run [7] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        logic exp_vld;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, seq[i]);
            exp_vld = (i > 0);
            total++;
            if (dir_vld !== exp_vld || err !== 1'b0 || run_len !== exp_run[i] ||
                (exp_vld && dir !== 1'b1))
                $display("FAIL up_cycle[%0d]: vld=%0b dir=%0b err=%0b run=%0d, want vld=%0b dir=1 err=0 run=%0d",
                         i, dir_vld, dir, err, run_len, exp_vld, exp_run[i]);
            else passed++;
        end
    endtask

    task automatic test_down_wrap();
        logic [2:0] seq [5] = '{3'd2, 3'd1, 3'd0, 3'd4, 3'd3};
        logic [7:0] exp_run [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        logic exp_vld;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i]);
            exp_vld = (i > 0);
            total++;
            if (dir_vld !== exp_vld || err !== 1'b0 || run_len !== exp_run[i] ||
                (exp_vld && dir !== 1'b0))
                $display("FAIL down_wrap[%0d]: vld=%0b dir=%0b err=%0b run=%0d, want vld=%0b dir=0 err=0 run=%0d",
                         i, dir_vld, dir, err, run_len, exp_vld, exp_run[i]);
            else passed++;
        end
    endtask

    task automatic test_dir_change();
        logic [2:0] seq [5] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
        logic       exp_dir [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] exp_run [5] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2};
        do_reset();
        step(1'b1, seq[0]);
        for (int i = 1; i < 5; i++) begin
            step(1'b1, seq[i]);
            total++;
            if (dir_vld !== 1'b1 || dir !== exp_dir[i] || run_len !== exp_run[i] || err !== 1'b0)
                $display("FAIL dir_change[%0d]: vld=%0b dir=%0b run=%0d err=%0b, want vld=1 dir=%0b run=%0d err=0",
                         i, dir_vld, dir, run_len, err, exp_dir[i], exp_run[i]);
            else passed++;
        end
    endtask

    task automatic test_errors();
        do_reset();
        step(1'b1, 3'd1);
        step(1'b1, 3'd2);
        step(1'b1, 3'd2);
        total++;
        if (err !== 1'b1 || dut.state !== PRIMED || dir_vld !== 1'b0 || run_len !== 8'd0)
            $display("FAIL bad_step: err=%0b state=%0d vld=%0b run=%0d, want err=1 state=PRIMED vld=0 run=0",
                     err, dut.state, dir_vld, run_len);
        else passed++;

        step(1'b1, 3'd3);
        total++;
        if (err !== 1'b0 || dir_vld !== 1'b1 || dir !== 1'b1 || run_len !== 8'd1)
            $display("FAIL recover: err=%0b vld=%0b dir=%0b run=%0d, want err=0 vld=1 dir=1 run=1",
                     err, dir_vld, dir, run_len);
        else passed++;

        step(1'b1, 3'd6);
        total++;
        if (err !== 1'b1 || dut.state !== EMPTY || dut.prev !== 3'd3 || dir_vld !== 1'b0 || run_len !== 8'd0)
            $display("FAIL illegal_code: err=%0b state=%0d prev=%0d vld=%0b run=%0d, want err=1 state=EMPTY prev=3 vld=0 run=0",
                     err, dut.state, dut.prev, dir_vld, run_len);
        else passed++;
`ifdef CNT5_DEC_ERRCNT_EN
        total++;
        if (err_cnt !== 8'd2) $display("FAIL err_cnt_two: got %0d want 2", err_cnt);
        else passed++;
`endif

        step(1'b1, 3'd7);
        total++;
        if (err !== 1'b1 || dut.state !== EMPTY)
            $display("FAIL back_to_back_err: err=%0b state=%0d, want err=1 state=EMPTY", err, dut.state);
        else passed++;

        step(1'b0, 3'd5);
        total++;
        if (err !== 1'b0) $display("FAIL err_single_cycle: err=%0b want 0", err);
        else passed++;

        step(1'b1, 3'd2);
        total++;
        if (err !== 1'b0 || dut.state !== PRIMED || dir_vld !== 1'b0)
            $display("FAIL reprime: err=%0b state=%0d vld=%0b, want err=0 state=PRIMED vld=0",
                     err, dut.state, dir_vld);
        else passed++;
`ifdef CNT5_DEC_ERRCNT_EN
        total++;
        if (err_cnt !== 8'd3) $display("FAIL err_cnt_three: got %0d want 3", err_cnt);
        else passed++;
`endif
    endtask

    task automatic test_gaps_and_reset();
        do_reset();
        step(1'b1, 3'd0);
        step(1'b1, 3'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd4);
            total++;
            if (dir_vld !== 1'b1 || dir !== 1'b1 || run_len !== 8'd1 || err !== 1'b0)
                $display("FAIL gap_hold[%0d]: vld=%0b dir=%0b run=%0d err=%0b, want vld=1 dir=1 run=1 err=0",
                         i, dir_vld, dir, run_len, err);
            else passed++;
        end
        step(1'b1, 3'd2);
        total++;
        if (dir_vld !== 1'b1 || dir !== 1'b1 || run_len !== 8'd2 || err !== 1'b0)
            $display("FAIL after_gap: vld=%0b dir=%0b run=%0d err=%0b, want vld=1 dir=1 run=2 err=0",
                     dir_vld, dir, run_len, err);
        else passed++;

        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({dir_vld, dir, err, run_len} !== 11'd0 || dut.state !== EMPTY || dut.prev !== 3'd0)
            $display("FAIL async_reset: vld=%0b dir=%0b err=%0b run=%0d state=%0d prev=%0d, want all 0",
                     dir_vld, dir, err, run_len, dut.state, dut.prev);
        else passed++;
        @(negedge clk);
        reset = 1'b0;

        step(1'b1, 3'd3);
        total++;
        if (dir_vld !== 1'b0 || err !== 1'b0 || dut.state !== PRIMED)
            $display("FAIL post_reset_prime: vld=%0b err=%0b state=%0d, want vld=0 err=0 state=PRIMED",
                     dir_vld, err, dut.state);
        else passed++;
        step(1'b1, 3'd4);
        total++;
        if (dir_vld !== 1'b1 || dir !== 1'b1 || run_len !== 8'd1)
            $display("FAIL post_reset_first: vld=%0b dir=%0b run=%0d, want vld=1 dir=1 run=1",
                     dir_vld, dir, run_len);
        else passed++;
    endtask

    task automatic test_saturation();
        logic [2:0] v;
        logic [2:0] exp_run;
        do_reset();
        v = 3'd0;
        @(negedge clk); en2 = 1'b1; cnt2 = v;
        @(posedge clk); #1;
        for (int i = 1; i <= 10; i++) begin
            v = (v == 3'd4) ? 3'd0 : v + 3'd1;
            exp_run = (i > 7) ? 3'd7 : 3'(i);
            @(negedge clk); cnt2 = v;
            @(posedge clk); #1;
            total++;
            if (dir_vld2 !== 1'b1 || dir2 !== 1'b1 || run_len2 !== exp_run || err2 !== 1'b0)
                $display("FAIL sat_up[%0d]: vld=%0b dir=%0b run=%0d err=%0b, want vld=1 dir=1 run=%0d err=0",
                         i, dir_vld2, dir2, run_len2, err2, exp_run);
            else passed++;
        end
        @(negedge clk); cnt2 = 3'd4;
        @(posedge clk); #1;
        total++;
        if (dir_vld2 !== 1'b1 || dir2 !== 1'b0 || run_len2 !== 3'd1)
            $display("FAIL sat_reverse: vld=%0b dir=%0b run=%0d, want vld=1 dir=0 run=1",
                     dir_vld2, dir2, run_len2);
        else passed++;
        @(negedge clk); en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_cycle();
        test_down_wrap();
        test_dir_change();
        test_errors();
        test_gaps_and_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cnt5_dir_decoder.md
# cnt5_dir_decoder

Receiving-side companion to the mod-5 up/down counter. It samples a 3-bit mod-5 count stream, one value per enabled clock, and recovers the direction bit that produced each step: up (+1 mod 5) or down (−1 mod 5). It also flags illegal codes and illegal steps, and tracks how many consecutive steps went the same way. It sits downstream of any block that emits the counter's 3-bit state, and is used for link checking and debug observation.

## Interface
- RUN_W, 8, width of the saturating same-direction run counter
- ERR_W, 8, width of the saturating error counter (present only with the macro)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  sample strobe; cnt_in is consumed only on edges where en=1
- cnt_in  input  3  observed count; legal codes are 0..4
- dir  output  1  last decoded direction (1=up/inc, 0=down/dec)
- dir_vld  output  1  level signal; high while state=LOCK
- err  output  1  one-cycle pulse on an illegal code or illegal step
- run_len  output  RUN_W  consecutive same-direction steps, saturating at all-ones
- err_cnt  output  ERR_W  total errors, saturating (present only with the macro)

## Operation
- **Internal registers:** prev[2:0] and a state register with three states: EMPTY, PRIMED, LOCK.
- **Step classification** of cnt_in against prev:
  - UP if cnt_in == (prev+1) mod 5.
  - DOWN if cnt_in == (prev+4) mod 5.
  - ILLEGAL_CODE if cnt_in > 4.
  - BAD_STEP otherwise, including cnt_in == prev, because the counter moves every clock.
- **Wrap cases:** 4→0 is UP; 0→4 is DOWN.
- **EMPTY**, on en=1:
  - Legal code: prev←cnt_in, go to PRIMED.
  - ILLEGAL_CODE: err pulse, stay in EMPTY.
- **PRIMED / LOCK**, on en=1:
  - UP or DOWN: prev←cnt_in, dir←(UP), go to LOCK.
    - run_len←1 if entering from PRIMED or if the direction changed.
    - Otherwise run_len←run_len+1, saturating.
  - BAD_STEP: err pulse, prev←cnt_in, run_len←0, go to PRIMED.
  - ILLEGAL_CODE: err pulse, run_len←0, go to EMPTY; prev is not updated.
- **en=0:** all registers hold and err=0.
- **dir** holds its last value outside LOCK. Ignore it whenever dir_vld=0.

## Timing
- **Reset values:** state=EMPTY, prev=0, dir=0, dir_vld=0, err=0, run_len=0, err_cnt=0.
- **Reset behaviour:** reset takes effect immediately and asynchronously. Reset asserted mid-stream discards prev. After release, decoding restarts from EMPTY, so the first sample after release only primes the decoder.
- **Registered outputs:** all outputs are registered.
- **Latency:** a sample taken at edge k updates dir, dir_vld, run_len and err visibly after edge k.
- **First direction:** the first valid direction appears after the second legal enabled sample.
- **err width:** exactly one cycle per offending sample. Back-to-back bad samples give back-to-back err pulses.
- **Saturation:**
  - run_len stops at 2^RUN_W−1 and still resets to 1 on a direction change.
  - err_cnt stops at 2^ERR_W−1.

## Configuration
- **Macro:** CNT5_DEC_ERRCNT_EN.
- **Defined:** the err_cnt port and its ERR_W-bit saturating counter exist. err_cnt increments on every err pulse.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Structure
- **Package cnt5_pkg** holds:
  - The code constants ZERO..FOUR (3'd0..3'd4).
  - The decoder state enum {EMPTY, PRIMED, LOCK}.
  - The step-class enum {UP, DOWN, BAD_STEP, ILLEGAL_CODE}.
  - Functions inc5() and dec5() returning (x+1) mod 5 and (x+4) mod 5.
- **Sub-module cnt5_step_cmp:** a purely combinational classifier with inputs prev and cnt_in and the step class as output. The top level contains the FSM and the counters.

## Test plan
- **Full up cycle:** reset, then en=1 with cnt_in 0,1,2,3,4,0,1.
  - dir_vld rises after the 2nd sample; dir=1 throughout.
  - run_len reads 1,2,3,4,5,6; err never asserts.
- **Down through the wrap:** cnt_in 2,1,0,4,3. Requires dir=0 and run_len reaching 4; the 0→4 step is not an error.
- **Direction change:** cnt_in 0,1,2,1,0. Requires dir 1,1,0,0 and run_len 1,2,1,2.
- **Errors:**
  - cnt_in 1,2,2: err pulses on the third sample, state goes to PRIMED, and dir_vld drops.
  - Next sample 3: requires dir_vld=1, dir=1, run_len=1.
  - A sample of 6: requires err, state EMPTY, prev unchanged. With the macro defined, err_cnt=2 at this point.
- **Gaps and reset:**
  - cnt_in 0,1 then en=0 for 3 cycles while cnt_in=4: outputs hold and no err.
  - Then en=1 with 2: run_len=2.
  - Assert reset mid-stream: outputs go to their reset values immediately, and the next sample only primes the decoder.
- **Saturation:** with RUN_W=3, issue 10 up steps. run_len must saturate at 7, then read 1 after one down step.
